// File: rtl/led_snap_buf.sv
// LED debug snapshot buffer: debounced capture/browse buttons fill and walk an
// 8-entry history of led_in words, shown on led_out while freeze is high.
module led_snap_buf #(
  parameter int DB_CYCLES = 50000,
  parameter int DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] led_in,
  input  logic        btn_cap,
  input  logic        btn_prev,
  input  logic        freeze,
  output logic [15:0] led_out,
  output logic [3:0]  count,
  output logic [2:0]  idx
);

  localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  // bit 0 = capture button, bit 1 = browse button
  logic [1:0]       btn_raw;
  logic [1:0]       btn_s1_p0, btn_s2_p1, btn_db_p2, btn_db_d_p2;
  logic [CNT_W-1:0] db_cnt_p2 [2];
  logic             frz_s1_p0, frz_s2_p1, frz_d_p2;
  logic             cap_p, prev_p, frz_rise;

  logic [15:0]      hist_mem [DEPTH];
  logic [2:0]       wr_ptr;
  logic [2:0]       rd_ptr;
  logic [15:0]      led_sel;
  logic [15:0]      led_p3;

  assign btn_raw = {btn_prev, btn_cap};

  // Stages p0/p1: two-flop synchronizers; p2: debounce and edge history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1_p0   <= '0;
      btn_s2_p1   <= '0;
      btn_db_p2   <= '0;
      btn_db_d_p2 <= '0;
      frz_s1_p0   <= 1'b0;
      frz_s2_p1   <= 1'b0;
      frz_d_p2    <= 1'b0;
      for (int i = 0; i < 2; i++) db_cnt_p2[i] <= '0;
    end else begin
      btn_s1_p0   <= btn_raw;
      btn_s2_p1   <= btn_s1_p0;
      btn_db_d_p2 <= btn_db_p2;
      frz_s1_p0   <= freeze;
      frz_s2_p1   <= frz_s1_p0;
      frz_d_p2    <= frz_s2_p1;
      for (int i = 0; i < 2; i++) begin
        if (btn_s2_p1[i] == btn_db_p2[i]) begin
          db_cnt_p2[i] <= '0;
        end else if (db_cnt_p2[i] == DB_LAST) begin
          btn_db_p2[i] <= btn_s2_p1[i];
          db_cnt_p2[i] <= '0;
        end else begin
          db_cnt_p2[i] <= db_cnt_p2[i] + 1'b1;
        end
      end
    end
  end

  assign cap_p    = btn_db_p2[0] & ~btn_db_d_p2[0];
  assign prev_p   = btn_db_p2[1] & ~btn_db_d_p2[1];
  assign frz_rise = frz_s2_p1 & ~frz_d_p2;

  // Stage p3: history bookkeeping; capture outranks browse and freeze edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      count  <= '0;
      idx    <= '0;
    end else if (cap_p) begin
      wr_ptr <= wr_ptr + 3'd1;
      if (count != 4'd8) count <= count + 4'd1;
      idx    <= '0;
    end else if (frz_rise) begin
      idx <= '0;
    end else if (prev_p && (count != 4'd0)) begin
      idx <= (({1'b0, idx} + 4'd1) < count) ? idx + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_p) hist_mem[wr_ptr] <= led_in;
  end

  assign rd_ptr = wr_ptr - 3'd1 - idx;

  always_comb begin
    led_sel = '0;
    if (!frz_s2_p1) led_sel = led_in;
    else if (count != 4'd0) led_sel = hist_mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) led_p3 <= '0;
    else      led_p3 <= led_sel;
  end

  assign led_out = led_p3;

endmodule
